// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler: FSM encoding and default widths.
package timer_sched_pkg;

  localparam int unsigned N_REQ_DEFAULT = 4;
  localparam int unsigned DW_DEFAULT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/timer_scheduler_rr_picker.sv
// Round-robin picker: returns the first set request at or after ptr, wrapping mod N_REQ.
module rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             valid,
  output logic [IDW-1:0]   idx
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  // Walk candidates ptr, ptr+1, .. (mod N_REQ); equivalent to rotate/find-first/un-rotate.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N_REQ)) begin
        sum = sum - (IDW+1)'(N_REQ);
      end
      cand = sum[IDW-1:0];
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one one-shot interval timer between N_REQ requesters with round-robin arbitration.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter  int unsigned N_REQ = N_REQ_DEFAULT,
  parameter  int unsigned DW    = DW_DEFAULT,
  localparam int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_i,
  input  logic [N_REQ*DW-1:0] dur_i,
  output logic [N_REQ-1:0]  done_o,
  output logic              busy_o,
  output logic [IDW-1:0]    gnt_id_o,
  output logic [DW-1:0]     timer_n_o,
  output logic              timer_start_o,
  input  logic              timer_end_i
);

  sched_state_e     state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   gnt_d;
  logic [DW-1:0]    n_d;
  logic [N_REQ-1:0] done_d;
  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;
  logic [DW-1:0]    dur_sel;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_picker (
    .req   (req_i),
    .ptr   (rr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Duration of the current pick candidate.
  always_comb begin
    dur_sel = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick_idx == IDW'(k)) begin
        dur_sel = dur_i[k*DW +: DW];
      end
    end
  end

  // Next-state and next-output logic; outputs are registered from the *_d values.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_id_o;
    n_d     = timer_n_o;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d = pick_idx;
          n_d   = dur_sel;
          // Zero duration skips the timer: it would read n=0 as a full wrap.
          state_d = (dur_sel != '0) ? LAUNCH : DONE;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (timer_end_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rr_d    = (gnt_id_o == IDW'(N_REQ-1)) ? '0 : gnt_id_o + IDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) begin
      done_d[gnt_d] = 1'b1;
    end
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      gnt_id_o      <= '0;
      timer_n_o     <= '0;
      done_o        <= '0;
      busy_o        <= 1'b0;
      timer_start_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      gnt_id_o      <= gnt_d;
      timer_n_o     <= n_d;
      done_o        <= done_d;
      busy_o        <= (state_d != IDLE);
      timer_start_o <= (state_d == LAUNCH);
    end
  end

endmodule
